// File: rtl/fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared CPU constants used by the fetch queue and the PC stage.
//   NOP_INSTR : instruction word presented when no valid entry is available
//   RESET_PC  : address the PC stage starts fetching from after reset
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

endpackage

// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the fetch-side push port, the decode-side pop port and the status
// outputs of the fetch queue.
//   PushValid/PushPC/PushInstr : fetched instruction offered by fetch
//   Full                       : queue cannot accept a push (PC stall)
//   PopReady                   : decode accepts the head entry
//   Flush                      : redirect, discard every queued entry
//   OutValid/OutPC/OutInstr    : head entry (gated to 0 / NOP when empty)
//   Count                      : number of valid entries
// Modports: master = fetch/decode side, slave = the queue itself.
// ----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
);
    import fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          PushValid;
    logic [AW-1:0] PushPC;
    logic [AW-1:0] PushInstr;
    logic          Full;
    logic          PopReady;
    logic          Flush;
    logic          OutValid;
    logic [AW-1:0] OutPC;
    logic [AW-1:0] OutInstr;
    logic [CW-1:0] Count;

    modport master (
        output PushValid, PushPC, PushInstr, PopReady, Flush,
        input  Full, OutValid, OutPC, OutInstr, Count
    );

    modport slave (
        input  PushValid, PushPC, PushInstr, PopReady, Flush,
        output Full, OutValid, OutPC, OutInstr, Count
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// ----------------------------------------------------------------------------
// fetch_queue_mem
// Entry storage for the fetch queue: DEPTH words of W bits, one synchronous
// write port and one asynchronous read port. Contents are never reset; the
// owner masks stale words with its own valid tracking.
//   clk     : clock
//   wr_en   : write wr_data to wr_addr on the rising edge
//   wr_addr : write index
//   wr_data : word to store
//   rd_addr : read index
//   rd_data : word at rd_addr (combinational)
// ----------------------------------------------------------------------------
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [PW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Circular instruction queue between fetch and decode. Holds DEPTH {PC,
// instruction} pairs; pointers and occupancy live here, the entries live in
// fetch_queue_mem. No bypass: a push is visible at the head one cycle later.
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous active-low reset, highest priority
//   fq    : fetch_queue_if slave port (push, pop, flush and status signals)
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_queue_if.slave fq
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic [2*AW-1:0] head;

    // Status comes from registered count only, so Full never depends on
    // PopReady and a full queue rejects a push even when it pops.
    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);

    // A flush discards any same-cycle push or pop, including the write.
    assign push = fq.PushValid && !full && !fq.Flush;
    assign pop  = out_valid && fq.PopReady && !fq.Flush;

    always_ff @(posedge Clk) begin
        if (!Reset || fq.Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are PW bits wide, so DEPTH being a power of two makes
            // the natural overflow the modulo-DEPTH wrap.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (2 * AW)
    ) u_mem (
        .clk     (Clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({fq.PushPC, fq.PushInstr}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Storage is never cleared, so the head is masked whenever it is stale.
    assign fq.Full     = full;
    assign fq.OutValid = out_valid;
    assign fq.Count    = count;
    assign fq.OutPC    = out_valid ? head[2*AW-1:AW] : '0;
    assign fq.OutInstr = out_valid ? head[AW-1:0]    : AW'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (DEPTH=4, AW=32) with hand-computed
// expected values for fill, drain, wrap, flush, reset and full push+pop.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_queue_if #(.DEPTH(4), .AW(32)) fq ();

    fetch_queue #(
        .DEPTH (4),
        .AW    (32)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .fq    (fq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic pr, input logic fl);
        fq.PushValid = pv;
        fq.PushPC    = pc;
        fq.PushInstr = ins;
        fq.PopReady  = pr;
        fq.Flush     = fl;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        check("rst_count", 32'(fq.Count), 32'd0);
        check("rst_full", 32'(fq.Full), 32'd0);
        check("rst_valid", 32'(fq.OutValid), 32'd0);
        check("rst_pc", fq.OutPC, 32'h0);
        check("rst_instr", fq.OutInstr, 32'h0);
        reset = 1'b1;

        // Fill to full, then a fifth push is ignored.
        drive(1'b1, 32'h3000, 32'h0010_0093, 1'b0, 1'b0);
        #1;
        check("no_bypass", 32'(fq.OutValid), 32'd0);
        tick();
        check("push1_valid", 32'(fq.OutValid), 32'd1);
        check("push1_pc", fq.OutPC, 32'h3000);
        check("push1_instr", fq.OutInstr, 32'h0010_0093);
        check("push1_count", 32'(fq.Count), 32'd1);
        drive(1'b1, 32'h3004, 32'h0020_0113, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3008, 32'h0030_0193, 1'b0, 1'b0);
        tick();
        check("push3_full", 32'(fq.Full), 32'd0);
        check("push3_count", 32'(fq.Count), 32'd3);
        drive(1'b1, 32'h300C, 32'h0040_0213, 1'b0, 1'b0);
        tick();
        check("push4_full", 32'(fq.Full), 32'd1);
        check("push4_count", 32'(fq.Count), 32'd4);
        drive(1'b1, 32'h3010, 32'h0050_0293, 1'b0, 1'b0);
        tick();
        check("push5_count", 32'(fq.Count), 32'd4);
        check("push5_full", 32'(fq.Full), 32'd1);
        check("push5_head", fq.OutPC, 32'h3000);

        // Drain in order.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("pop0_pc", fq.OutPC, 32'h3000);
        tick();
        check("pop1_pc", fq.OutPC, 32'h3004);
        check("pop1_instr", fq.OutInstr, 32'h0020_0113);
        tick();
        check("pop2_pc", fq.OutPC, 32'h3008);
        tick();
        check("pop3_pc", fq.OutPC, 32'h300C);
        check("pop3_instr", fq.OutInstr, 32'h0040_0213);
        tick();
        check("drain_valid", 32'(fq.OutValid), 32'd0);
        check("drain_instr", fq.OutInstr, 32'h0);
        check("drain_pc", fq.OutPC, 32'h0);
        check("drain_count", 32'(fq.Count), 32'd0);
        tick();
        check("pop_empty_count", 32'(fq.Count), 32'd0);
        check("pop_empty_full", 32'(fq.Full), 32'd0);

        // Streaming push+pop: occupancy stays 1, pointers wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h3100 + 32'(4 * i), 32'h0010_0013 + 32'(i), 1'b1, 1'b0);
            tick();
            check("stream_count", 32'(fq.Count), 32'd1);
            check("stream_pc", fq.OutPC, 32'h3100 + 32'(4 * i));
            check("stream_instr", fq.OutInstr, 32'h0010_0013 + 32'(i));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("stream_end_count", 32'(fq.Count), 32'd0);

        // Flush with a simultaneous push.
        drive(1'b1, 32'h3200, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3204, 32'h0000_0002, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3208, 32'h0000_0003, 1'b0, 1'b0);
        tick();
        check("preflush_count", 32'(fq.Count), 32'd3);
        drive(1'b1, 32'h3020, 32'h0000_0004, 1'b0, 1'b1);
        tick();
        check("flush_count", 32'(fq.Count), 32'd0);
        check("flush_valid", 32'(fq.OutValid), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("flush_nopush_count", 32'(fq.Count), 32'd0);
        check("flush_nopush_pc", fq.OutPC, 32'h0);
        drive(1'b1, 32'h3030, 32'h0000_0005, 1'b0, 1'b0);
        tick();
        check("postflush_pc", fq.OutPC, 32'h3030);
        check("postflush_count", 32'(fq.Count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("postflush_drain", 32'(fq.Count), 32'd0);

        // Full queue with push+pop: push rejected, head advances.
        drive(1'b1, 32'h3300, 32'h0000_0010, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3304, 32'h0000_0011, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3308, 32'h0000_0012, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h330C, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        check("fpp_full_before", 32'(fq.Full), 32'd1);
        drive(1'b1, 32'h3310, 32'h0000_0014, 1'b1, 1'b0);
        tick();
        check("fpp_count", 32'(fq.Count), 32'd3);
        check("fpp_full", 32'(fq.Full), 32'd0);
        check("fpp_head", fq.OutPC, 32'h3304);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("fpp_pop1", fq.OutPC, 32'h3308);
        tick();
        check("fpp_pop2", fq.OutPC, 32'h330C);
        tick();
        check("fpp_empty", 32'(fq.OutValid), 32'd0);
        check("fpp_empty_count", 32'(fq.Count), 32'd0);

        // Reset mid-occupancy beats push, pop and flush.
        drive(1'b1, 32'h3400, 32'h0000_0020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3404, 32'h0000_0021, 1'b0, 1'b0);
        tick();
        check("prereset_count", 32'(fq.Count), 32'd2);
        reset = 1'b0;
        drive(1'b1, 32'h3500, 32'h0000_0022, 1'b1, 1'b1);
        tick();
        check("midreset_count", 32'(fq.Count), 32'd0);
        check("midreset_valid", 32'(fq.OutValid), 32'd0);
        reset = 1'b1;
        drive(1'b1, 32'h3000, 32'h0000_0513, 1'b0, 1'b0);
        tick();
        check("postreset_count", 32'(fq.Count), 32'd1);
        check("postreset_pc", fq.OutPC, 32'h3000);
        check("postreset_instr", fq.OutInstr, 32'h0000_0513);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
